sa_operand_streamer: RTL and testbench

SA_OPERAND_STREAMER -- requirements
Module: sa_operand_streamer

---
 rtl/sa_operand_streamer.sv | 246 ++++++++++++++++++++++++
 tb/tb_sa_operand_streamer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sa_operand_streamer.sv
// Operand streamer feeding A/B lanes of a systolic array from a small operand buffer.
// Define SA_STREAM_SKEW_EN to stagger lane n by n handshakes and drain the skew in FLUSH.
module sa_operand_streamer #(
  parameter int WIDTH = 8,
  parameter int HPE   = 4,
  parameter int VPE   = 4,
  parameter int DEPTH = 16
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [2*WIDTH-1:0]         wr_data,
  input  logic                       start,
  input  logic [15:0]                num_beats,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [WIDTH*HPE-1:0]       AA,
  output logic [WIDTH*VPE-1:0]       BB,
  output logic                       busy,
  output logic                       done
);

  localparam int AW   = $clog2(DEPTH);
  localparam int STEP = (HPE > VPE) ? HPE : VPE;
  localparam int FW   = $clog2(STEP + 1);
  localparam logic [AW-1:0] STEP_A = AW'(STEP);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [15:0]         beats_left_q, beats_left_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [WIDTH-1:0]    aa_q [HPE];
  logic [WIDTH-1:0]    aa_d [HPE];
  logic [WIDTH-1:0]    bb_q [VPE];
  logic [WIDTH-1:0]    bb_d [VPE];
  logic [2*WIDTH-1:0]  mem_q [DEPTH];

  logic                wr_fire;
  logic                hs;
  logic                load;
  logic                zero_raw;
  logic                clear_hist;
  logic [AW-1:0]       src_base;
  logic [WIDTH-1:0]    raw_a [HPE];
  logic [WIDTH-1:0]    raw_b [VPE];

`ifdef SA_STREAM_SKEW_EN
  logic [FW-1:0]       flush_cnt_q, flush_cnt_d;
  logic [WIDTH-1:0]    hist_a_q [HPE][HPE];
  logic [WIDTH-1:0]    hist_a_d [HPE][HPE];
  logic [WIDTH-1:0]    hist_b_q [VPE][VPE];
  logic [WIDTH-1:0]    hist_b_d [VPE][VPE];
`endif

  assign wr_fire = wr_en && (state_q == IDLE) && !RST;
  assign hs      = out_valid_q && out_ready;

  always_comb begin
    state_d      = state_q;
    rd_ptr_d     = rd_ptr_q;
    beats_left_d = beats_left_q;
    out_valid_d  = out_valid_q;
    done_d       = 1'b0;
    load         = 1'b0;
    zero_raw     = 1'b0;
    clear_hist   = 1'b0;
    src_base     = rd_ptr_q + STEP_A;
`ifdef SA_STREAM_SKEW_EN
    flush_cnt_d  = flush_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          beats_left_d = num_beats;
          rd_ptr_d     = '0;
          clear_hist   = 1'b1;
          if (num_beats == 16'd0) begin
            done_d = 1'b1;
          end else begin
            state_d     = RUN;
            out_valid_d = 1'b1;
            load        = 1'b1;
            src_base    = '0;
          end
        end
      end
      RUN: begin
        if (hs) begin
          beats_left_d = beats_left_q - 16'd1;
          rd_ptr_d     = rd_ptr_q + STEP_A;
          if (beats_left_q == 16'd1) begin
`ifdef SA_STREAM_SKEW_EN
            if (STEP > 1) begin
              state_d     = FLUSH;
              flush_cnt_d = FW'(STEP - 1);
              load        = 1'b1;
              zero_raw    = 1'b1;
            end else begin
              state_d     = IDLE;
              out_valid_d = 1'b0;
              done_d      = 1'b1;
            end
`else
            state_d     = IDLE;
            out_valid_d = 1'b0;
            done_d      = 1'b1;
`endif
          end else begin
            load = 1'b1;
          end
        end
      end
      FLUSH: begin
`ifdef SA_STREAM_SKEW_EN
        // Zeros enter the skew chains until the deepest lane has emitted its last operand.
        if (hs) begin
          if (flush_cnt_q == FW'(1)) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            done_d      = 1'b1;
          end else begin
            flush_cnt_d = flush_cnt_q - FW'(1);
            load        = 1'b1;
            zero_raw    = 1'b1;
          end
        end
`else
        state_d     = IDLE;
        out_valid_d = 1'b0;
`endif
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Operand fetch; a write in the same IDLE cycle as start is forwarded to the first beat.
  always_comb begin
    logic [AW-1:0]      addr;
    logic [2*WIDTH-1:0] ent;
    addr = '0;
    ent  = '0;
    for (int n = 0; n < HPE; n++) begin
      addr = src_base + AW'(n);
      ent  = mem_q[addr];
      if (wr_fire && (wr_addr == addr)) ent = wr_data;
      raw_a[n] = zero_raw ? '0 : ent[2*WIDTH-1:WIDTH];
    end
    for (int m = 0; m < VPE; m++) begin
      addr = src_base + AW'(m);
      ent  = mem_q[addr];
      if (wr_fire && (wr_addr == addr)) ent = wr_data;
      raw_b[m] = zero_raw ? '0 : ent[WIDTH-1:0];
    end
  end

  always_comb begin
    aa_d = aa_q;
    bb_d = bb_q;
`ifdef SA_STREAM_SKEW_EN
    hist_a_d = hist_a_q;
    hist_b_d = hist_b_q;
    if (clear_hist) begin
      for (int n = 0; n < HPE; n++)
        for (int j = 0; j < HPE; j++) hist_a_d[n][j] = '0;
      for (int m = 0; m < VPE; m++)
        for (int j = 0; j < VPE; j++) hist_b_d[m][j] = '0;
    end
    // Lane n shows the raw operand from n beats ago; history shifts on every new beat.
    if (load) begin
      for (int n = 0; n < HPE; n++) begin
        if (n == 0) aa_d[n] = raw_a[n];
        else        aa_d[n] = clear_hist ? '0 : hist_a_q[n][(n > 0) ? n - 1 : 0];
        hist_a_d[n][0] = raw_a[n];
        for (int j = 1; j < HPE; j++) hist_a_d[n][j] = clear_hist ? '0 : hist_a_q[n][j-1];
      end
      for (int m = 0; m < VPE; m++) begin
        if (m == 0) bb_d[m] = raw_b[m];
        else        bb_d[m] = clear_hist ? '0 : hist_b_q[m][(m > 0) ? m - 1 : 0];
        hist_b_d[m][0] = raw_b[m];
        for (int j = 1; j < VPE; j++) hist_b_d[m][j] = clear_hist ? '0 : hist_b_q[m][j-1];
      end
    end
`else
    if (load) begin
      for (int n = 0; n < HPE; n++) aa_d[n] = raw_a[n];
      for (int m = 0; m < VPE; m++) bb_d[m] = raw_b[m];
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      rd_ptr_q     <= '0;
      beats_left_q <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      for (int n = 0; n < HPE; n++) aa_q[n] <= '0;
      for (int m = 0; m < VPE; m++) bb_q[m] <= '0;
`ifdef SA_STREAM_SKEW_EN
      flush_cnt_q  <= '0;
      for (int n = 0; n < HPE; n++)
        for (int j = 0; j < HPE; j++) hist_a_q[n][j] <= '0;
      for (int m = 0; m < VPE; m++)
        for (int j = 0; j < VPE; j++) hist_b_q[m][j] <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      beats_left_q <= beats_left_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aa_q         <= aa_d;
      bb_q         <= bb_d;
`ifdef SA_STREAM_SKEW_EN
      flush_cnt_q  <= flush_cnt_d;
      hist_a_q     <= hist_a_d;
      hist_b_q     <= hist_b_d;
`endif
    end
    if (wr_fire) mem_q[wr_addr] <= wr_data;
  end

  for (genvar n = 0; n < HPE; n++) begin : g_aa
    assign AA[n*WIDTH +: WIDTH] = aa_q[n];
  end
  for (genvar m = 0; m < VPE; m++) begin : g_bb
    assign BB[m*WIDTH +: WIDTH] = bb_q[m];
  end

  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sa_operand_streamer.sv
// Directed bench for sa_operand_streamer (HPE=VPE=4, WIDTH=8, DEPTH=16); buffer holds {i+0x10, i}.
module tb_sa_operand_streamer;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        start = 1'b0;
  logic [15:0] num_beats = '0;
  logic        out_ready = 1'b1;
  logic        out_valid;
  logic [31:0] AA;
  logic [31:0] BB;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  sa_operand_streamer #(.WIDTH(8), .HPE(4), .VPE(4), .DEPTH(16)) dut (
    .CLK(clk), .RST(RST), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .num_beats(num_beats), .out_ready(out_ready), .out_valid(out_valid),
    .AA(AA), .BB(BB), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Expected lanes for a beat starting at buffer entry b.
  function automatic logic [31:0] exp_aa(input int b);
    logic [31:0] r;
    for (int n = 0; n < 4; n++) r[n*8 +: 8] = 8'(16 + ((b + n) % 16));
    return r;
  endfunction

  function automatic logic [31:0] exp_bb(input int b);
    logic [31:0] r;
    for (int n = 0; n < 4; n++) r[n*8 +: 8] = 8'((b + n) % 16);
    return r;
  endfunction

  task automatic load_buffer;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_addr = 4'(i);
      wr_data = {8'(i + 16), 8'(i)};
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic test_reset;
    RST   = 1'b1;
    start = 1'b1;
    num_beats = 16'd3;
    repeat (2) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (AA !== 32'h0) begin n_fail++; $display("FAIL reset_AA: got %h expected 0", AA); end
    n_checks++; if (BB !== 32'h0) begin n_fail++; $display("FAIL reset_BB: got %h expected 0", BB); end
    RST   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_start_prio: got valid %b expected 0", out_valid); end
  endtask

  task automatic test_two_beats;
    @(negedge clk);
    start = 1'b1; num_beats = 16'd2; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || AA !== 32'h13121110 || BB !== 32'h03020100) begin
      n_fail++; $display("FAIL two_beat0: got v=%b AA=%h BB=%h expected v=1 AA=13121110 BB=03020100", out_valid, AA, BB); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL two_busy: got %b expected 1", busy); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1 || AA !== 32'h17161514 || BB !== 32'h07060504 || done !== 1'b0) begin
      n_fail++; $display("FAIL two_beat1: got v=%b AA=%h BB=%h done=%b expected v=1 AA=17161514 BB=07060504 done=0", out_valid, AA, BB, done); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL two_done: got v=%b done=%b busy=%b expected 0 1 0", out_valid, done, busy); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL two_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_wrap;
    @(negedge clk);
    start = 1'b1; num_beats = 16'd5; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      start = 1'b0;
      n_checks++; if (out_valid !== 1'b1 || AA !== exp_aa((4 * k) % 16) || BB !== exp_bb((4 * k) % 16) || done !== 1'b0) begin
        n_fail++; $display("FAIL wrap_beat%0d: got v=%b AA=%h BB=%h done=%b expected v=1 AA=%h BB=%h done=0",
                           k, out_valid, AA, BB, done, exp_aa((4 * k) % 16), exp_bb((4 * k) % 16)); end
    end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0 || done !== 1'b1) begin
      n_fail++; $display("FAIL wrap_done: got v=%b done=%b expected 0 1", out_valid, done); end
  endtask

  task automatic test_stall;
    @(negedge clk);
    start = 1'b1; num_beats = 16'd3; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      n_checks++; if (out_valid !== 1'b1 || AA !== 32'h13121110 || BB !== 32'h03020100) begin
        n_fail++; $display("FAIL stall_hold%0d: got v=%b AA=%h BB=%h expected v=1 AA=13121110 BB=03020100", c, out_valid, AA, BB); end
    end
    out_ready = 1'b1;
    for (int k = 1; k < 3; k++) begin
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1 || AA !== exp_aa(4 * k) || BB !== exp_bb(4 * k)) begin
        n_fail++; $display("FAIL stall_beat%0d: got v=%b AA=%h BB=%h expected v=1 AA=%h BB=%h", k, out_valid, AA, BB, exp_aa(4 * k), exp_bb(4 * k)); end
    end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0 || done !== 1'b1) begin
      n_fail++; $display("FAIL stall_done: got v=%b done=%b expected 0 1", out_valid, done); end
  endtask

  task automatic test_busy_ignore;
    @(negedge clk);
    start = 1'b1; num_beats = 16'd2; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b1; num_beats = 16'd7;
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hBEEF;
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    n_checks++; if (done !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL busy_done: got done=%b v=%b expected 1 0", done, out_valid); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL busy_restart: got v=%b busy=%b expected 0 0", out_valid, busy); end
    start = 1'b1; num_beats = 16'd1;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (AA !== 32'h13121110 || BB !== 32'h03020100) begin
      n_fail++; $display("FAIL busy_write: got AA=%h BB=%h expected 13121110 03020100", AA, BB); end
    @(negedge clk);
  endtask

  task automatic test_same_cycle_write;
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hA055;
    start = 1'b1; num_beats = 16'd1; out_ready = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; start = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || AA !== 32'h131211A0 || BB !== 32'h03020155) begin
      n_fail++; $display("FAIL same_cycle_write: got v=%b AA=%h BB=%h expected v=1 AA=131211a0 BB=03020155", out_valid, AA, BB); end
    @(negedge clk);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL same_cycle_done: got %b expected 1", done); end
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'h1000;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic test_zero_beats;
    @(negedge clk);
    start = 1'b1; num_beats = 16'd0;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (done !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL zero_done: got done=%b v=%b expected 1 0", done, out_valid); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL zero_after: got done=%b v=%b busy=%b expected 0 0 0", done, out_valid, busy); end
  endtask

  task automatic test_reset_mid_run;
    @(negedge clk);
    start = 1'b1; num_beats = 16'd3; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_checks++; if (AA !== 32'h17161514) begin n_fail++; $display("FAIL rst_run_beat1: got AA=%h expected 17161514", AA); end
    RST = 1'b1; start = 1'b1; num_beats = 16'd2;
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF;
    @(negedge clk);
    RST = 1'b0; start = 1'b0; wr_en = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || AA !== 32'h0 || BB !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL rst_run_outputs: got v=%b AA=%h BB=%h busy=%b done=%b expected all 0", out_valid, AA, BB, busy, done); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL rst_run_no_done: got v=%b done=%b expected 0 0", out_valid, done); end
    start = 1'b1; num_beats = 16'd1;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || AA !== 32'h13121110 || BB !== 32'h03020100) begin
      n_fail++; $display("FAIL rst_run_retained: got v=%b AA=%h BB=%h expected v=1 AA=13121110 BB=03020100", out_valid, AA, BB); end
    @(negedge clk);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL rst_run_done: got %b expected 1", done); end
  endtask

`ifdef SA_STREAM_SKEW_EN
  task automatic test_skew;
    logic [31:0] ea [4];
    logic [31:0] eb [4];
    ea[0] = 32'h00000010; eb[0] = 32'h00000000;
    ea[1] = 32'h00001100; eb[1] = 32'h00000100;
    ea[2] = 32'h00120000; eb[2] = 32'h00020000;
    ea[3] = 32'h13000000; eb[3] = 32'h03000000;
    @(negedge clk);
    start = 1'b1; num_beats = 16'd1; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      n_checks++; if (out_valid !== 1'b1 || AA !== ea[k] || BB !== eb[k] || done !== 1'b0) begin
        n_fail++; $display("FAIL skew_beat%0d: got v=%b AA=%h BB=%h done=%b expected v=1 AA=%h BB=%h done=0",
                           k, out_valid, AA, BB, done, ea[k], eb[k]); end
    end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0 || done !== 1'b1) begin
      n_fail++; $display("FAIL skew_done: got v=%b done=%b expected 0 1", out_valid, done); end
  endtask
`endif

  initial begin
    test_reset();
    load_buffer();
`ifdef SA_STREAM_SKEW_EN
    test_skew();
    test_zero_beats();
`else
    test_two_beats();
    test_wrap();
    test_stall();
    test_busy_ignore();
    test_same_cycle_write();
    test_zero_beats();
    test_reset_mid_run();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
